dsp_chain_sop_sched: RTL

- Job sequencer for an external 4-stage cascaded int_sop_2 chain, where each stage computes ax*ay + bx*by and adds its chainin.
- Accepts a dot-product job descriptor, then streams operand beats into the chain. One beat is 8 products.
- Skews each stage's operands to match the cascade timing, tracks in-flight beats and accumulates chain results into a wide accumulator.
- Returns one result per job on a valid/ready port. Sits between the operand-fetch logic and the DSP chain.

---
 rtl/dsp_chain_sop_sched_pkg.sv | 18 +
 rtl/dsp_chain_sop_sched_skew.sv | 41 ++++
 rtl/dsp_chain_sop_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dsp_chain_sop_sched_pkg.sv
// Shared definitions for the int_sop_2 chain job sequencer.
// Holds the operand and chain-result widths, the default chain depth and the
// sequencer state encoding.
package dsp_chain_sop_sched_pkg;

    localparam int X_W        = 18;  // x operand width (ax, bx)
    localparam int Y_W        = 19;  // y operand width (ay, by)
    localparam int CHAIN_W    = 37;  // final-stage chain result width
    localparam int NSTAGE_DEF = 4;   // default number of chained stages

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/dsp_chain_sop_sched_skew.sv
// sop_operand_skew: per-stage delay line for one packed operand bus.
// Stage s of the bus is delayed by s registers, so stage 0 passes straight
// through and stage NSTAGE-1 sees NSTAGE-1 cycles of delay. This lines each
// stage's operands up with the cascade arriving on its chainin.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset, clears every delay register
//   din   - packed operands, stage s in bits [W*s +: W]
//   dout  - skewed operands, same packing
module sop_operand_skew
    import dsp_chain_sop_sched_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int W      = X_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSTAGE*W-1:0]   din,
    output logic [NSTAGE*W-1:0]   dout
);

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        if (s == 0) begin : g_pass
            assign dout[W-1:0] = din[W-1:0];
        end else begin : g_dly
            logic [W-1:0] line [s];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < s; k++) line[k] <= '0;
                end else begin
                    line[0] <= din[s*W +: W];
                    for (int k = 1; k < s; k++) line[k] <= line[k-1];
                end
            end

            assign dout[s*W +: W] = line[s-1];
        end
    end

endmodule

// File: rtl/dsp_chain_sop_sched.sv
// dsp_chain_sop_sched: job sequencer for an external cascaded int_sop_2 chain.
// Accepts a job of cmd_len operand beats (8 products per beat), skews the
// operands into the chain, tracks in-flight beats with a token pipe and sums
// the chain results into a wrapping signed accumulator. One result per job.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   cmd_valid/ready/len    - job descriptor handshake and length in beats
//   in_valid/ready         - operand beat handshake
//   in_ax/bx, in_ay/by     - packed operands, stage s in [W*s +: W]
//   chain_ax/bx/ay/by      - skewed operands driven into the chain
//   chain_result           - signed final-stage result from the chain
//   res_valid/ready/data   - job result handshake, sign-extended sum
//   busy                   - sequencer not idle
module dsp_chain_sop_sched
    import dsp_chain_sop_sched_pkg::*;
#(
    parameter int NSTAGE   = NSTAGE_DEF,
    parameter int PIPE_LAT = 6,
    parameter int LEN_W    = 12,
    parameter int ACC_W    = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NSTAGE*X_W-1:0]   in_ax,
    input  logic [NSTAGE*X_W-1:0]   in_bx,
    input  logic [NSTAGE*Y_W-1:0]   in_ay,
    input  logic [NSTAGE*Y_W-1:0]   in_by,
    output logic [NSTAGE*X_W-1:0]   chain_ax,
    output logic [NSTAGE*X_W-1:0]   chain_bx,
    output logic [NSTAGE*Y_W-1:0]   chain_ay,
    output logic [NSTAGE*Y_W-1:0]   chain_by,
    input  logic [CHAIN_W-1:0]      chain_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic                    busy
);

    // Two's-complement add of a sign-extended chain result; wraps at ACC_W.
    function automatic logic signed [ACC_W-1:0] wrap_add(
        input logic signed [ACC_W-1:0]   a,
        input logic signed [CHAIN_W-1:0] b
    );
        return a + ACC_W'(b);
    endfunction

    state_t                   state, state_nxt;
    logic [LEN_W-1:0]         remain;
    logic [PIPE_LAT-1:0]      tok_p;
    logic signed [ACC_W-1:0]  acc;

    logic accept;
    logic cmd_take;
    logic last_beat;

    logic [NSTAGE*X_W-1:0] ax_p0, bx_p0;
    logic [NSTAGE*Y_W-1:0] ay_p0, by_p0;

    assign accept    = in_valid & in_ready;
    assign cmd_take  = cmd_valid & cmd_ready;
    assign last_beat = accept && (remain == LEN_W'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = (cmd_len == '0) ? OUT : LOAD;
            LOAD:    if (last_beat) state_nxt = DRAIN;
            // An empty token pipe means the last beat's accumulate has landed.
            DRAIN:   if (tok_p == '0) state_nxt = OUT;
            OUT:     if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            LOAD:    in_ready  = (remain != '0);
            OUT:     res_valid = 1'b1;
            default: ;
        endcase
    end

    // Stage p0: gate operands so bubbles push zeros through the skew lines
    assign ax_p0 = accept ? in_ax : '0;
    assign bx_p0 = accept ? in_bx : '0;
    assign ay_p0 = accept ? in_ay : '0;
    assign by_p0 = accept ? in_by : '0;

    // Stage p1..: per-stage skew into the chain
    sop_operand_skew #(.NSTAGE(NSTAGE), .W(X_W)) u_skew_ax (
        .clk(clk), .reset(reset), .din(ax_p0), .dout(chain_ax)
    );
    sop_operand_skew #(.NSTAGE(NSTAGE), .W(X_W)) u_skew_bx (
        .clk(clk), .reset(reset), .din(bx_p0), .dout(chain_bx)
    );
    sop_operand_skew #(.NSTAGE(NSTAGE), .W(Y_W)) u_skew_ay (
        .clk(clk), .reset(reset), .din(ay_p0), .dout(chain_ay)
    );
    sop_operand_skew #(.NSTAGE(NSTAGE), .W(Y_W)) u_skew_by (
        .clk(clk), .reset(reset), .din(by_p0), .dout(chain_by)
    );

    // Token pipe, beat counter and accumulator; the token leaving the pipe
    // marks the cycle in which chain_result carries that beat's sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remain <= '0;
            tok_p  <= '0;
            acc    <= '0;
        end else begin
            tok_p <= {tok_p[PIPE_LAT-2:0], accept};
            if (cmd_take) begin
                remain <= cmd_len;
                acc    <= '0;
            end else begin
                if (accept)
                    remain <= remain - LEN_W'(1);
                if (tok_p[PIPE_LAT-1])
                    acc <= wrap_add(acc, chain_result);
            end
        end
    end

    assign res_data = acc;

endmodule
